cic_decimator: RTL and testbench
================================

CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have ports: EN  in  1  clock enable; 0 freezes all internal state and y_n.
REQ-004 SHALL have ports: bypass  in  1  1 routes x_n to y_n through one register; filter state still advances when EN=1.
REQ-005 SHALL have ports: x_n  in  16  signed input sample, s16.15 two's complement, one sample per enabled cycle.
REQ-006 SHALL have ports: Decimation_Factor  in  3  log2 of rate change; D = 1<<Decimation_Factor (0..4 -> D=1,2,4,8,16); codes 5..7 treated as 4 (D=16).
REQ-007 SHALL have ports: y_n  out  16  signed output, s16.15, registered, held between decimated updates.
REQ-008 SHALL have parameters: DATA_WIDTH, default 16, width of x_n/y_n.
REQ-009 SHALL have parameters: N_STAGES, default 3, number of integrator and comb stages, differential delay M=1.

Function
REQ-010 SHALL implement N_STAGES cascaded integrators at input rate, then a D-to-1 downsampler, then N_STAGES combs (y[k] = u[k] - u[k-1]) at output rate.
REQ-011 SHALL size internal integrator/comb registers at DATA_WIDTH + N_STAGES*4 bits (28 bits at defaults), sign-extending x_n; integrators wrap modulo 2^width (no saturation inside).
REQ-012 SHALL register each integrator stage, one stage per enabled cycle.
REQ-013 SHALL keep a phase counter 0..D-1 advancing on each enabled cycle; the decimation strobe is counter == D-1.
REQ-014 SHALL compute the comb chain from the last integrator value on the strobe cycle and load the result into y_n on that same edge.
REQ-015 SHALL leave y_n unchanged on all other cycles.
REQ-016 SHALL normalise DC gain D^N_STAGES by arithmetic right shift of N_STAGES*Decimation_Factor bits (0 shift for D=1).
REQ-017 SHALL then saturate to [-32768, 32767]; DC input x SHALL settle to output x exactly.
REQ-018 SHALL, with D=1, produce y_n equal to x_n delayed by N_STAGES+1 enabled cycles.
REQ-019 SHALL, with bypass=1, set y_n = x_n on every enabled edge (latency 1); bypass deassert resumes filtered output at the next strobe.
REQ-020 SHALL, with EN=0, hold integrators, combs, counter and y_n; EN=0 has priority over strobe.
REQ-021 SHALL, on a Decimation_Factor change, restart the phase counter at 0; integrator/comb state is kept; the first N_STAGES outputs after a change are undefined in value but SHALL not trigger X.

Reset
REQ-022 SHALL, while rst_n=0, clear asynchronously all integrators, comb delays, phase counter and y_n to 0.
REQ-023 SHALL, after rst_n deasserts, produce the first strobe on the D-th enabled cycle.
REQ-024 SHALL, on reset mid-operation, discard all history; no partial sums survive.

Configuration
REQ-025 SHALL support macro CIC_ROUND_EN: when defined, add 2^(shift-1) before the normalising shift (round half up; no add when shift=0).
REQ-026 SHALL, when CIC_ROUND_EN is undefined, truncate (plain arithmetic shift).
REQ-027 SHALL apply saturation in both builds.

Verification
REQ-028 SHALL be verified for reset: rst_n=0 with x_n=0x7FFF -> y_n=0x0000 immediately and held.
REQ-029 SHALL be verified for DC with D=4: x_n=0x4000 constant, EN=1 -> y_n settles to 0x4000 after 3 decimated outputs, updating every 4 cycles.
REQ-030 SHALL be verified for negative full scale with D=16: x_n=0x8000 constant -> y_n settles to 0x8000, no wrap.
REQ-031 SHALL be verified for D=1 impulse: single 0x7FFF sample then zeros -> y_n=0x7FFF exactly 4 cycles later for one cycle, then 0x0000.
REQ-032 SHALL be verified for bypass: bypass=1, x_n=0x1234 -> y_n=0x1234 on next edge, for all D.
REQ-033 SHALL be verified for enable: EN=0 for 10 cycles during D=8 DC run of 0x2000 -> y_n and phase frozen; resumes with same phase, output still 0x2000.

Source files
------------

// File: rtl/cic_decimator.sv
// N-stage CIC decimator (M=1): integrators at input rate, D=1<<Decimation_Factor downsampler,
// combs at output rate, DC-gain shift and saturation. Define CIC_ROUND_EN to round before the shift.
module cic_decimator #(
   parameter int DATA_WIDTH = 16,
   parameter int N_STAGES   = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         EN,
   input  logic                         bypass,
   input  logic signed [DATA_WIDTH-1:0] x_n,
   input  logic        [2:0]            Decimation_Factor,
   output logic signed [DATA_WIDTH-1:0] y_n
);

   localparam int ACC_W = DATA_WIDTH + N_STAGES*4;
   localparam int NRM_W = ACC_W + 1;
   localparam logic signed [NRM_W-1:0] SAT_MAX =
      {{(NRM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [NRM_W-1:0] SAT_MIN =
      {{(NRM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [ACC_W-1:0]      integ    [N_STAGES];
   logic signed [ACC_W-1:0]      comb_dly [N_STAGES];
   logic signed [ACC_W-1:0]      comb_in  [N_STAGES];
   logic signed [ACC_W-1:0]      comb_out;
   logic        [2:0]            fac;
   logic        [2:0]            fac_q;
   logic        [3:0]            phase;
   logic        [3:0]            phase_eff;
   logic        [3:0]            phase_last;
   logic        [3:0]            phase_nxt;
   logic                         strobe;
   logic        [7:0]            shift_amt;
   logic signed [NRM_W-1:0]      norm_sum;
   logic signed [NRM_W-1:0]      norm;
   logic signed [DATA_WIDTH-1:0] y_sat;

   // A factor change restarts counting with the current cycle as phase 0.
   always_comb begin
      fac        = (Decimation_Factor > 3'd4) ? 3'd4 : Decimation_Factor;
      phase_last = 4'((5'd1 << fac) - 5'd1);
      phase_eff  = (fac != fac_q) ? 4'd0 : phase;
      strobe     = (phase_eff == phase_last);
      phase_nxt  = strobe ? 4'd0 : phase_eff + 4'd1;
   end

   // NOTE: every variable of a combinational block is assigned before any conditional use, so no latch is inferred.
   always_comb begin
      logic signed [ACC_W-1:0] acc;
      acc = integ[N_STAGES-1];
      for (int i = 0; i < N_STAGES; i++) begin
         comb_in[i] = acc;
         acc        = acc - comb_dly[i];
      end
      comb_out = acc;
   end

   always_comb begin
      shift_amt = 8'(N_STAGES * int'(fac));
      norm_sum  = NRM_W'(comb_out);
`ifdef CIC_ROUND_EN
      if (shift_amt != 8'd0)
         norm_sum = norm_sum + (NRM_W'(1) <<< (shift_amt - 8'd1));
`endif
      norm = norm_sum >>> shift_amt;
      if (norm > SAT_MAX)
         y_sat = SAT_MAX[DATA_WIDTH-1:0];
      else if (norm < SAT_MIN)
         y_sat = SAT_MIN[DATA_WIDTH-1:0];
      else
         y_sat = norm[DATA_WIDTH-1:0];
   end

   // NOTE: integrator and comb arrays are cleared element by element in reset; a surviving partial sum would bias every later output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_STAGES; i++) begin
            integ[i]    <= '0;
            comb_dly[i] <= '0;
         end
         phase <= '0;
         fac_q <= '0;
         y_n   <= '0;
      end else if (EN) begin
         // NOTE: non-blocking updates make each stage add its predecessor's previous value, one stage per cycle.
         integ[0] <= integ[0] + ACC_W'(x_n);
         for (int i = 1; i < N_STAGES; i++)
            integ[i] <= integ[i] + integ[i-1];
         phase <= phase_nxt;
         fac_q <= fac;
         if (strobe) begin
            for (int i = 0; i < N_STAGES; i++)
               comb_dly[i] <= comb_in[i];
         end
         if (bypass)
            y_n <= x_n;
         else if (strobe)
            y_n <= y_sat;
      end
   end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: a FIR-of-boxcars reference model plus literal spot checks.
module tb_cic_decimator;

   localparam int N = 3;

   logic               CLK_tb = 1'b0;
   logic               rst_n;
   logic               EN;
   logic               bypass;
   logic signed [15:0] x_n;
   logic        [2:0]  Decimation_Factor;
   logic signed [15:0] y_n;

   int total = 0;
   int bad   = 0;

   // Reference model state: the CIC equals N cascaded length-D boxcars, a delay of N, then decimation.
   int x_hist[$];
   int h[64];
   int h_len;
   int m_phase;
   int m_fac;
   int m_y;
   int m_undef;
   bit m_valid;
   bit m_fresh;

   always #5 CLK_tb = ~CLK_tb;

   cic_decimator dut (
      .clk              (CLK_tb),
      .rst_n            (rst_n),
      .EN               (EN),
      .bypass           (bypass),
      .x_n              (x_n),
      .Decimation_Factor(Decimation_Factor),
      .y_n              (y_n)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic build_h(input int fac);
      int d;
      int tmp[64];
      d     = 1 << fac;
      h_len = 1;
      h[0]  = 1;
      repeat (N) begin
         for (int k = 0; k < h_len + d - 1; k++) begin
            tmp[k] = 0;
            for (int m = 0; m < d; m++)
               if (k - m >= 0 && k - m < h_len) tmp[k] += h[k-m];
         end
         h_len = h_len + d - 1;
         for (int k = 0; k < h_len; k++) h[k] = tmp[k];
      end
   endtask

   function automatic int model_out(input int t);
      longint acc;
      int     sh;
      acc = 0;
      for (int j = 0; j < h_len; j++)
         if (t - N - j >= 0) acc += longint'(h[j]) * longint'(x_hist[t-N-j]);
      sh = N * m_fac;
`ifdef CIC_ROUND_EN
      if (sh > 0) acc += longint'(1) << (sh - 1);
`endif
      acc = acc >>> sh;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   task automatic model_clear();
      x_hist.delete();
      m_phase = 0;
      m_fac   = 0;
      m_y     = 0;
      m_undef = 0;
      m_valid = 1'b1;
      m_fresh = 1'b1;
   endtask

   // One clock: drive, advance the model on the edge, compare 1 time unit later.
   task automatic step(input bit en, input bit byp, input logic signed [15:0] x, input int fac);
      int fc;
      int d;
      bit strb;
      bit undef_now;
      EN                = en;
      bypass            = byp;
      x_n               = x;
      Decimation_Factor = 3'(fac);
      @(posedge CLK_tb);
      if (en) begin
         fc = (fac > 4) ? 4 : fac;
         if (m_fresh) begin
            m_fresh = 1'b0;
            m_fac   = fc;
            build_h(fc);
         end else if (fc != m_fac) begin
            m_fac   = fc;
            m_phase = 0;
            m_undef = N;
            build_h(fc);
         end
         x_hist.push_back(int'(x));
         d         = 1 << m_fac;
         strb      = (m_phase == d - 1);
         m_phase   = strb ? 0 : m_phase + 1;
         undef_now = 1'b0;
         if (strb && m_undef > 0) begin
            m_undef--;
            undef_now = 1'b1;
         end
         if (byp) begin
            m_y     = int'(x);
            m_valid = 1'b1;
         end else if (strb) begin
            if (undef_now) m_valid = 1'b0;
            else begin
               m_y     = model_out(x_hist.size() - 1);
               m_valid = 1'b1;
            end
         end
      end
      #1;
      if (m_valid) check("model_track", int'(y_n), m_y);
      else         check("undef_no_x", int'($isunknown(y_n)), 0);
   endtask

   task automatic do_reset(input logic signed [15:0] x);
      rst_n = 1'b0;
      x_n   = x;
      EN    = 1'b1;
      #1;
      check("reset_async", int'(y_n), 0);
      repeat (2) begin
         @(posedge CLK_tb);
         #1;
         check("reset_hold", int'(y_n), 0);
      end
      model_clear();
      @(negedge CLK_tb);
      rst_n = 1'b1;
   endtask

   initial begin
      logic signed [15:0] xr;
      int fac;
      rst_n             = 1'b0;
      EN                = 1'b0;
      bypass            = 1'b0;
      x_n               = '0;
      Decimation_Factor = '0;

      // Reset with full-scale input on x_n.
      do_reset(16'sh7FFF);

      // D=1 impulse: output equals the sample on the 4th edge, then returns to zero.
      step(1, 0, 16'sh7FFF, 0);
      check("imp_e0", int'(y_n), 0);
      step(1, 0, 16'sh0000, 0);
      step(1, 0, 16'sh0000, 0);
      check("imp_e2", int'(y_n), 0);
      step(1, 0, 16'sh0000, 0);
      check("imp_e3", int'(y_n), 32767);
      step(1, 0, 16'sh0000, 0);
      check("imp_e4", int'(y_n), 0);

      // DC 0x4000 at D=4.
      do_reset(16'sh0000);
      repeat (24) step(1, 0, 16'sh4000, 2);
      check("dc_d4", int'(y_n), 16'h4000);

      // Negative full scale at D=16.
      do_reset(16'sh0000);
      repeat (100) step(1, 0, 16'sh8000, 4);
      check("negfs_d16", int'(y_n), -32768);

      // Bypass for every factor code.
      do_reset(16'sh0000);
      for (int f = 0; f < 8; f++) begin
         step(1, 1, 16'sh1234, f);
         check("bypass", int'(y_n), 16'h1234);
      end

      // Enable freeze during a D=8 DC run.
      do_reset(16'sh0000);
      repeat (64) step(1, 0, 16'sh2000, 3);
      check("en_pre", int'(y_n), 16'h2000);
      repeat (10) begin
         xr = 16'($urandom);
         step(0, 0, xr, 3);
         check("en_freeze", int'(y_n), 16'h2000);
      end
      repeat (5) step(1, 0, 16'sh2000, 3);
      check("en_resume", int'(y_n), 16'h2000);
      repeat (40) step(1, 0, 16'sh2000, 3);
      check("en_settled", int'(y_n), 16'h2000);

      // Randomized runs: enables, bypass, factor changes, one mid-run reset.
      for (int r = 0; r < 6; r++) begin
         do_reset(16'($urandom));
         fac = $urandom_range(0, 7);
         for (int i = 0; i < 400; i++) begin
            if (i == 150 && r != 0) fac = $urandom_range(0, 7);
            if (i == 200 && r == 2) do_reset(16'($urandom));
            case ($urandom_range(0, 9))
               0:       xr = 16'sh7FFF;
               1:       xr = 16'sh8000;
               default: xr = 16'($urandom);
            endcase
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, xr, fac);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
